// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-input registered select stage with valid/ready handshake.
// A main output register plus one skid register give full throughput while
// keeping in_ready a pure function of registered state (no out_ready -> in_ready path).
// Selects at or above N_IN produce zero data with out_err set.
module mux_nx1_pipe #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_IN*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic             out_err_q,   out_err_d;

   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q,  skid_data_d;
   logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;
   logic             skid_err_q,   skid_err_d;

   logic [WIDTH-1:0] sel_data;
   logic             sel_err;
   logic             accept;
   logic             xfer;

   // Pick the addressed input; an unmatched select yields zero data and an error flag.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int k = 0; k < N_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
   end

   assign accept = in_valid & ~skid_valid_q;
   assign xfer   = out_valid_q & out_ready;

   // Next-state for main and skid entries: flush wins, then refill main, then fill skid.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_sel_d   = skid_sel_q;
      skid_err_d   = skid_err_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || xfer) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_sel_d    = skid_sel_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = in_sel;
            out_err_d   = sel_err;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = sel_data;
         skid_sel_d   = in_sel;
         skid_err_d   = sel_err;
      end
   end

   // Entry registers; reset drops both entries immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sel_q    <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_sel_q   <= '0;
         skid_err_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_sel_q   <= skid_sel_d;
         skid_err_q   <= skid_err_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: four parameter sets, a per-instance FIFO reference
// model fed on accepted handshakes, and a monitor popping on each output transfer.
module tb_mux_nx1_pipe;

   localparam int CW[4] = '{32, 32, 8, 64};
   localparam int CN[4] = '{4, 3, 2, 5};

   typedef struct {
      logic [63:0] d;
      logic [2:0]  s;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] word [4][5];
   logic [2:0]  sel_t [4];
   logic        vld [4];
   logic        rdy [4];
   logic        fl  [4];
   logic        ir  [4];
   logic        ov  [4];
   logic        oe  [4];
   logic [2:0]  os  [4];
   logic [63:0] od  [4];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   genvar c, k;
   for (c = 0; c < 4; c++) begin : g
      localparam int W = CW[c];
      localparam int N = CN[c];
      localparam int S = $clog2(N);
      localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

      logic [N*W-1:0] in_data;
      logic [S-1:0]   in_sel;
      logic           in_ready;
      logic [W-1:0]   out_data;
      logic [S-1:0]   out_sel;
      logic           out_err;
      logic           out_valid;
      exp_t           q[$];
      int             cnt;

      for (k = 0; k < N; k++) begin : gw
         assign in_data[k*W +: W] = word[c][k][W-1:0];
      end
      assign in_sel = sel_t[c][S-1:0];
      assign ir[c]  = in_ready;
      assign ov[c]  = out_valid;
      assign oe[c]  = out_err;
      assign os[c]  = 3'(out_sel);
      assign od[c]  = 64'(out_data);

      mux_nx1_pipe #(.WIDTH(W), .N_IN(N)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (in_data),
         .in_sel    (in_sel),
         .in_valid  (vld[c]),
         .in_ready  (in_ready),
         .flush     (fl[c]),
         .out_data  (out_data),
         .out_sel   (out_sel),
         .out_err   (out_err),
         .out_valid (out_valid),
         .out_ready (rdy[c])
      );

      // Reference occupancy model: push the expected entry on every accepted handshake.
      always @(posedge clk or negedge rst_n) begin
         exp_t e;
         int   si;
         logic acc, xf;
         if (!rst_n) begin
            q.delete();
            cnt = 0;
         end else begin
            chk($sformatf("in_ready[%0d]", c), 64'(in_ready), 64'(cnt < 2));
            chk($sformatf("out_valid[%0d]", c), 64'(out_valid), 64'(cnt > 0));
            acc = vld[c] && in_ready;
            xf  = out_valid && rdy[c];
            if (fl[c]) begin
               q.delete();
               cnt = 0;
            end else begin
               if (acc) begin
                  si  = int'(in_sel);
                  e.s = 3'(in_sel);
                  if (si < N) begin
                     e.d = word[c][si] & MASK;
                     e.e = 1'b0;
                  end else begin
                     e.d = 64'd0;
                     e.e = 1'b1;
                  end
                  q.push_back(e);
               end
               cnt = cnt + int'(acc) - int'(xf);
            end
         end
      end

      // Monitor: every output transfer must match the oldest expected entry.
      always @(negedge clk) begin
         exp_t e;
         if (rst_n && out_valid && rdy[c]) begin
            if (q.size() == 0) begin
               chk($sformatf("unexpected_out[%0d]", c), 64'(out_data), 64'hdead_beef);
            end else begin
               e = q.pop_front();
               chk($sformatf("sb_data[%0d]", c), 64'(out_data), e.d);
               chk($sformatf("sb_sel[%0d]", c), 64'(out_sel), 64'(e.s));
               chk($sformatf("sb_err[%0d]", c), 64'(out_err), 64'(e.e));
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         vld[i] = 1'b0; rdy[i] = 1'b0; fl[i] = 1'b0; sel_t[i] = 3'd0;
         for (int j = 0; j < 5; j++) word[i][j] = 64'd0;
      end
      word[0][0] = 64'h1111_1111; word[0][1] = 64'h2222_2222;
      word[0][2] = 64'h3333_3333; word[0][3] = 64'h4444_4444;
      word[1][0] = 64'haaaa_aaaa; word[1][1] = 64'hbbbb_bbbb;
      word[1][2] = 64'hcccc_cccc;

      #12;
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_out_data", od[0], 64'd0);
      chk("rst_out_sel", 64'(os[0]), 64'd0);
      chk("rst_out_err", 64'(oe[0]), 64'd0);
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;

      // Stream 0..3 with out_ready high.
      rdy[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld[0] = 1'b1; sel_t[0] = 3'(i);
         chk("stream_in_ready", 64'(ir[0]), 64'd1);
         cyc(1);
         chk("stream_data", od[0], 64'h1111_1111 * 64'(i + 1));
         chk("stream_valid", 64'(ov[0]), 64'd1);
      end
      vld[0] = 1'b0;
      cyc(1);
      chk("stream_drain", 64'(ov[0]), 64'd0);

      // Back-pressure: sel 2,3,0 with out_ready dropping after the first.
      vld[0] = 1'b1; sel_t[0] = 3'd2;
      cyc(1);
      rdy[0] = 1'b0; sel_t[0] = 3'd3;
      chk("bp_ready_skid", 64'(ir[0]), 64'd1);
      cyc(1);
      sel_t[0] = 3'd0;
      chk("bp_ready_low", 64'(ir[0]), 64'd0);
      cyc(3);
      chk("bp_ready_held", 64'(ir[0]), 64'd0);
      chk("bp_hold_data", od[0], 64'h3333_3333);
      rdy[0] = 1'b1;
      cyc(1);
      chk("bp_release_data", od[0], 64'h4444_4444);
      chk("bp_release_ready", 64'(ir[0]), 64'd1);
      cyc(1);
      chk("bp_third_data", od[0], 64'h1111_1111);
      vld[0] = 1'b0;
      cyc(1);

      // Out-of-range select on the 3-input instance.
      rdy[1] = 1'b1; vld[1] = 1'b1; sel_t[1] = 3'd3;
      cyc(1);
      chk("oor_data", od[1], 64'd0);
      chk("oor_err", 64'(oe[1]), 64'd1);
      chk("oor_sel", 64'(os[1]), 64'd3);
      sel_t[1] = 3'd2;
      cyc(1);
      chk("inr_data", od[1], 64'hcccc_cccc);
      chk("inr_err", 64'(oe[1]), 64'd0);
      chk("inr_sel", 64'(os[1]), 64'd2);
      vld[1] = 1'b0;
      cyc(1);

      // Flush with main and skid both full, out_ready low.
      rdy[0] = 1'b0; vld[0] = 1'b1; sel_t[0] = 3'd0;
      cyc(1);
      sel_t[0] = 3'd1;
      cyc(1);
      chk("fl_full_ready", 64'(ir[0]), 64'd0);
      fl[0] = 1'b1; sel_t[0] = 3'd2;
      cyc(1);
      fl[0] = 1'b0; vld[0] = 1'b0;
      chk("fl_valid", 64'(ov[0]), 64'd0);
      chk("fl_ready", 64'(ir[0]), 64'd1);
      rdy[0] = 1'b1;
      cyc(3);
      chk("fl_nothing_left", 64'(ov[0]), 64'd0);

      // Flush discards a same-cycle accept while main is stalled.
      rdy[0] = 1'b0; vld[0] = 1'b1; sel_t[0] = 3'd3;
      cyc(1);
      fl[0] = 1'b1; sel_t[0] = 3'd1;
      cyc(1);
      fl[0] = 1'b0; vld[0] = 1'b0;
      chk("fl_acc_valid", 64'(ov[0]), 64'd0);
      rdy[0] = 1'b1;
      cyc(2);

      // Flush with out_ready high: the held entry still transfers.
      vld[0] = 1'b1; sel_t[0] = 3'd2;
      cyc(1);
      fl[0] = 1'b1; sel_t[0] = 3'd3;
      cyc(1);
      fl[0] = 1'b0; vld[0] = 1'b0;
      chk("fl_xfer_valid", 64'(ov[0]), 64'd0);
      cyc(1);

      // Asynchronous reset between edges during a stall.
      rdy[0] = 1'b0; vld[0] = 1'b1; sel_t[0] = 3'd0;
      cyc(1);
      sel_t[0] = 3'd1;
      cyc(1);
      vld[0] = 1'b0;
      chk("ar_pre_ready", 64'(ir[0]), 64'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(ov[0]), 64'd0);
      chk("ar_data", od[0], 64'd0);
      chk("ar_ready", 64'(ir[0]), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      rdy[0] = 1'b1; vld[0] = 1'b1; sel_t[0] = 3'd3;
      cyc(1);
      chk("ar_resume0", od[0], 64'h4444_4444);
      sel_t[0] = 3'd2;
      cyc(1);
      chk("ar_resume1", od[0], 64'h3333_3333);
      vld[0] = 1'b0;
      cyc(1);

      // Randomised traffic on WIDTH=8/N_IN=2 and WIDTH=64/N_IN=5.
      for (int t = 0; t < 2000; t++) begin
         for (int i = 2; i < 4; i++) begin
            vld[i]   = ($urandom_range(0, 3) != 0);
            rdy[i]   = ($urandom_range(0, 9) < 7);
            fl[i]    = ($urandom_range(0, 39) == 0);
            sel_t[i] = 3'($urandom_range(0, (i == 2) ? 1 : 7));
            for (int j = 0; j < 5; j++) word[i][j] = {$urandom, $urandom};
         end
         cyc(1);
      end
      for (int i = 2; i < 4; i++) begin
         vld[i] = 1'b0; fl[i] = 1'b0; rdy[i] = 1'b1;
      end
      cyc(4);
      chk("rand_drain_w8", 64'(ov[2]), 64'd0);
      chk("rand_drain_w64", 64'(ov[3]), 64'd0);
      chk("rand_q_w8", 64'(g[2].q.size()), 64'd0);
      chk("rand_q_w64", 64'(g[3].q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
